imem_stream_loader: RTL

//   Hardware program loader for the pipeline core's instruction memory.

---
 rtl/imem_stream_loader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/imem_stream_loader.sv
// imem_stream_loader
//   Hardware program loader for the pipeline core's instruction memory. It takes a framed
//   byte stream and writes the payload into IMEM as little-endian 32-bit words, starting at
//   word 0. The frame is a 4-byte word count N (LSB first), then N words of 4 bytes each,
//   then one checksum byte. The 8-bit sum of every byte in the frame must be zero.
//   The core is held in reset for the whole load and is released only after a good checksum.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   load_start   1-cycle pulse that starts a load (honoured only in idle/done/error)
//   in_valid     byte-stream valid
//   in_data      byte-stream data
//   in_ready     loader can accept a byte (registered)
//   imem_we      IMEM write strobe, one cycle per word
//   imem_addr    IMEM word address
//   imem_wdata   IMEM write data {b3,b2,b1,b0}
//   core_rst     reset to the pipeline core; low only while the load is done
//   done         load completed with a good checksum (level)
//   error        load aborted: bad checksum or oversized header (level)
//   words_loaded number of words written in the current or last load

module imem_stream_loader #(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [31:0] DepthW = 32'(IMEM_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    state_e          state;
    logic [7:0]      sum;
    logic [1:0]      byte_cnt;
    logic [23:0]     byte_buf;   // first three bytes of the current header/word, b2 on top
    logic [ADDR_W:0] n_words;

    logic            accept;
    logic [31:0]     full_word;
    logic [7:0]      sum_next;
    logic [ADDR_W:0] wl_next;

    always_comb begin
        accept    = in_valid && in_ready;
        full_word = {in_data, byte_buf};
        sum_next  = sum + in_data;
        wl_next   = words_loaded + (ADDR_W + 1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // A write scheduled by this same edge is dropped because imem_we clears here.
            state        <= StIdle;
            in_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            core_rst     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            sum          <= '0;
            byte_cnt     <= '0;
            byte_buf     <= '0;
            n_words      <= '0;
        end else begin
            imem_we <= 1'b0;
            unique case (state)
                StIdle, StDone, StErr: begin
                    if (load_start) begin
                        state        <= StHdr;
                        in_ready     <= 1'b1;
                        core_rst     <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        sum          <= '0;
                        byte_cnt     <= '0;
                        words_loaded <= '0;
                    end
                end

                StHdr: begin
                    if (accept) begin
                        sum      <= sum_next;
                        byte_cnt <= byte_cnt + 2'd1;
                        byte_buf <= {in_data, byte_buf[23:8]};
                        if (byte_cnt == 2'd3) begin
                            if (full_word == 32'd0) begin
                                state <= StCsum;
                            end else if (full_word > DepthW) begin
                                state    <= StErr;
                                in_ready <= 1'b0;
                                error    <= 1'b1;
                            end else begin
                                state   <= StData;
                                n_words <= full_word[ADDR_W:0];
                            end
                        end
                    end
                end

                StData: begin
                    if (accept) begin
                        sum      <= sum_next;
                        byte_cnt <= byte_cnt + 2'd1;
                        byte_buf <= {in_data, byte_buf[23:8]};
                        if (byte_cnt == 2'd3) begin
                            imem_we      <= 1'b1;
                            imem_addr    <= words_loaded[ADDR_W-1:0];
                            imem_wdata   <= full_word;
                            words_loaded <= wl_next;
                            if (wl_next == n_words) begin
                                state <= StCsum;
                            end
                        end
                    end
                end

                StCsum: begin
                    if (accept) begin
                        sum      <= sum_next;
                        in_ready <= 1'b0;
                        if (sum_next == 8'd0) begin
                            state    <= StDone;
                            done     <= 1'b1;
                            core_rst <= 1'b0;
                        end else begin
                            state <= StErr;
                            error <= 1'b1;
                        end
                    end
                end

                default: begin
                    state    <= StIdle;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
